// File: rtl/turbo_frame_packer.sv
// Packs SYM_PER_FRAME saturated soft triplets into one frame and counts sync errors.
// Latency: frame valid one cycle after the last accept; in_ready_o drops (HOLD) only when a completed frame finds the output full.
module turbo_frame_packer #(
    parameter int SYM_PER_FRAME = 18,
    parameter int IN_W          = 6,
    parameter int LLR_W         = 4
) (
    input  logic                                  clk_p_i,
    input  logic                                  reset_n_i,
    input  logic                                  sof_i,
    input  logic signed [IN_W-1:0]                sys_i,
    input  logic signed [IN_W-1:0]                par1_i,
    input  logic signed [IN_W-1:0]                par2_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    output logic [3*SYM_PER_FRAME*LLR_W-1:0]      frame_o,
    output logic                                  frame_valid_o,
    input  logic                                  frame_ready_i,
    output logic [7:0]                            sync_err_o
);

    localparam int FLD_W   = SYM_PER_FRAME * LLR_W;
    localparam int FRAME_W = 3 * FLD_W;
    localparam int CNT_W   = $clog2(SYM_PER_FRAME);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(2 ** (LLR_W - 1) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = -SAT_MAX;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] acc;
    logic [FRAME_W-1:0] acc_nxt;
    logic [CNT_W-1:0]   idx;
    logic               accept;
    logic               slot_free;
    logic               err_inc;

    // Symmetric clamp: the most negative LLR code is never emitted.
    function automatic logic [LLR_W-1:0] sat(input logic signed [IN_W-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[LLR_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[LLR_W-1:0];
        else
            return v[LLR_W-1:0];
    endfunction

    assign in_ready_o = (state != ST_HOLD);
    assign accept     = in_valid_i && in_ready_o;
    assign slot_free  = !frame_valid_o || frame_ready_i;
    assign err_inc    = accept && (((state == ST_IDLE) && !sof_i) ||
                                   ((state == ST_FILL) &&  sof_i));

    // A start-of-frame restarts from an empty accumulator at symbol 0.
    always_comb begin
        idx     = sof_i ? '0 : cnt;
        acc_nxt = sof_i ? '0 : acc;
        for (int k = 0; k < SYM_PER_FRAME; k++) begin
            if (idx == CNT_W'(k)) begin
                acc_nxt[2*FLD_W + k*LLR_W +: LLR_W] = sat(par1_i);
                acc_nxt[FLD_W   + k*LLR_W +: LLR_W] = sat(sys_i);
                acc_nxt[          k*LLR_W +: LLR_W] = sat(par2_i);
            end
        end
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            acc           <= '0;
            frame_o       <= '0;
            frame_valid_o <= 1'b0;
            sync_err_o    <= '0;
        end else begin
            if (frame_valid_o && frame_ready_i)
                frame_valid_o <= 1'b0;

            if (err_inc && (sync_err_o != 8'hFF))
                sync_err_o <= sync_err_o + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (accept && sof_i) begin
                        acc   <= acc_nxt;
                        cnt   <= CNT_W'(1);
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        if (sof_i) begin
                            acc <= acc_nxt;
                            cnt <= CNT_W'(1);
                        end else if (cnt == CNT_W'(SYM_PER_FRAME - 1)) begin
                            cnt <= '0;
                            if (slot_free) begin
                                frame_o       <= acc_nxt;
                                frame_valid_o <= 1'b1;
                                state         <= ST_IDLE;
                            end else begin
                                acc   <= acc_nxt;
                                state <= ST_HOLD;
                            end
                        end else begin
                            acc <= acc_nxt;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (slot_free) begin
                        frame_o       <= acc;
                        frame_valid_o <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
